// File: rtl/crc8_pkg.sv
// crc8_pkg: CRC-8 constants, checker state encoding and the per-bit step shared with the transmit side.
package crc8_pkg;
   localparam logic [7:0] CRC8_POLY_DEFAULT = 8'h07;
   localparam logic [7:0] CRC8_INIT = 8'hFF;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b,
                                            input logic [7:0] poly = CRC8_POLY_DEFAULT);
      return {crc[6:0], 1'b0} ^ ((crc[7] ^ b) ? poly : 8'h00);
   endfunction
endpackage

// File: rtl/crc8_strip_dly.sv
// crc8_strip_dly: 4-beat delay line that forwards only payload beats (the trailing 4 CRC beats never fall out).
module crc8_strip_dly (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       push,
   input  logic [1:0] d,
   input  logic       last,
   output logic       pay_valid,
   output logic [1:0] pay_data,
   output logic       pay_last
);
   logic [3:0][1:0] dat;
   logic [3:0]      vld;
   assign pay_valid = push & vld[3];
   assign pay_data  = dat[3];
   assign pay_last  = pay_valid & last;
   always_ff @(posedge clk)
      if (rst | clr) vld <= '0;
      else if (push) vld <= {vld[2:0], 1'b1};
   always_ff @(posedge clk)
      if (push) dat <= {dat[2:0], d};
endmodule

// File: rtl/crc8_2bit_checker.sv
// crc8_2bit_checker: 2-bit/beat CRC-8 frame checker with length check.
// Optional payload forwarding (CRC beats stripped) under CRC8_CHK_STRIP_EN.
module crc8_2bit_checker
   import crc8_pkg::*;
#(
   parameter logic [7:0] POLY      = CRC8_POLY_DEFAULT,
   parameter logic [7:0] INIT      = CRC8_INIT,
   parameter int         MAX_BEATS = 1024,
   parameter int         CNT_W     = 11
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             init,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       din,
   input  logic             in_last,
   output logic             done,
   output logic             crc_ok,
   output logic             crc_err,
   output logic             len_err,
   output logic [7:0]       residue,
   output logic [CNT_W-1:0] frame_beats,
`ifdef CRC8_CHK_STRIP_EN
   output logic             pay_valid,
   output logic [1:0]       pay_data,
   output logic             pay_last,
`endif
   output logic             busy
);
   localparam logic [CNT_W-1:0] SAT = CNT_W'(MAX_BEATS + 1);
   localparam logic [CNT_W-1:0] MAX = CNT_W'(MAX_BEATS);
   state_t           state, state_nx;
   logic [7:0]       crc, crc_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic             acc, fin, lerr_nx;
   assign in_ready = state != DONE;
   assign acc      = in_valid & in_ready;
   assign fin      = acc & in_last;
   assign done     = state == DONE;
   assign busy     = state == RUN;
   assign lerr_nx  = (cnt_nx < CNT_W'(4)) | (cnt_nx > MAX);
   always_comb begin
      state_nx = state;
      crc_nx   = crc;
      cnt_nx   = cnt;
      if (state == DONE) begin
         state_nx = IDLE;
         crc_nx   = INIT;
         cnt_nx   = '0;
      end else if (acc) begin
         crc_nx   = crc8_step(crc8_step(crc, din[0], POLY), din[1], POLY);
         cnt_nx   = (cnt == SAT) ? cnt : cnt + 1'b1;
         state_nx = in_last ? DONE : RUN;
      end
   end
   // Results latch on the in_last edge so they are already valid while done is high.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         crc         <= INIT;
         cnt         <= '0;
         crc_ok      <= 1'b0;
         crc_err     <= 1'b0;
         len_err     <= 1'b0;
         residue     <= INIT;
         frame_beats <= '0;
      end else if (init) begin
         state <= IDLE;
         crc   <= INIT;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         crc   <= crc_nx;
         cnt   <= cnt_nx;
         if (fin) begin
            residue     <= crc_nx;
            frame_beats <= cnt_nx;
            len_err     <= lerr_nx;
            crc_ok      <= !lerr_nx & (crc_nx == 8'h00);
            crc_err     <= !lerr_nx & (crc_nx != 8'h00);
         end
      end
   end
`ifdef CRC8_CHK_STRIP_EN
   crc8_strip_dly u_dly (
      .clk       (clk),
      .rst       (rst),
      .clr       (init | done),
      .push      (acc),
      .d         (din),
      .last      (in_last),
      .pay_valid (pay_valid),
      .pay_data  (pay_data),
      .pay_last  (pay_last)
   );
`endif
endmodule

// File: tb/tb_crc8_2bit_checker.sv
// tb_crc8_2bit_checker: directed frames with hand-computed CRC results; a second instance uses MAX_BEATS=8.
// Payload-strip checks are active when CRC8_CHK_STRIP_EN is defined.
module tb_crc8_2bit_checker;
   logic       clk = 0, rst = 1, init = 0, in_valid = 0, in_last = 0;
   logic [1:0] din = '0;
   logic       in_ready, done, crc_ok, crc_err, len_err, busy;
   logic [7:0] residue;
   logic [10:0] frame_beats;
   logic       in_ready8, done8, crc_ok8, crc_err8, len_err8, busy8;
   logic [7:0] residue8;
   logic [3:0] frame_beats8;
   int         checks = 0, errors = 0;
`ifdef CRC8_CHK_STRIP_EN
   logic       pay_valid, pay_last, pay_valid8, pay_last8;
   logic [1:0] pay_data, pay_data8, pd_or;
   int         pv_cnt, pl_cnt;
   logic       pl_at_last;
`endif

   always #5 clk = ~clk;

   crc8_2bit_checker dut (
      .clk(clk), .rst(rst), .init(init), .in_valid(in_valid), .in_ready(in_ready),
      .din(din), .in_last(in_last), .done(done), .crc_ok(crc_ok), .crc_err(crc_err),
      .len_err(len_err), .residue(residue), .frame_beats(frame_beats),
`ifdef CRC8_CHK_STRIP_EN
      .pay_valid(pay_valid), .pay_data(pay_data), .pay_last(pay_last),
`endif
      .busy(busy)
   );

   crc8_2bit_checker #(.MAX_BEATS(8), .CNT_W(4)) dut8 (
      .clk(clk), .rst(rst), .init(init), .in_valid(in_valid), .in_ready(in_ready8),
      .din(din), .in_last(in_last), .done(done8), .crc_ok(crc_ok8), .crc_err(crc_err8),
      .len_err(len_err8), .residue(residue8), .frame_beats(frame_beats8),
`ifdef CRC8_CHK_STRIP_EN
      .pay_valid(pay_valid8), .pay_data(pay_data8), .pay_last(pay_last8),
`endif
      .busy(busy8)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [1:0] d, input logic l);
      int w = 0;
      @(negedge clk);
      while (!in_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      if (!in_ready) check("ready_timeout", in_ready, 1);
      din = d;
      in_last = l;
      in_valid = 1;
`ifdef CRC8_CHK_STRIP_EN
      #1;
      if (pay_valid) begin
         pv_cnt++;
         pd_or = pd_or | pay_data;
      end
      if (pay_last) pl_cnt++;
      if (l) pl_at_last = pay_last;
`endif
      @(posedge clk);
      #1;
      in_valid = 0;
      in_last = 0;
   endtask

   task automatic send_frame(input logic [31:0] beats, input int n, input int gap_at);
      for (int i = 0; i < n; i++) begin
         if (i == gap_at) begin
            repeat (3) @(posedge clk);
            #1;
            check("gap_busy", busy, 1);
            check("gap_ready", in_ready, 1);
         end
         send(beats[2*i+:2], i == n - 1);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 0;
      check("rst_ready", in_ready, 1);
      check("rst_done", done, 0);
      check("rst_ok", crc_ok, 0);
      check("rst_err", crc_err, 0);
      check("rst_len", len_err, 0);
      check("rst_residue", residue, 8'hFF);
      check("rst_beats", frame_beats, 0);
      check("rst_busy", busy, 0);

      // payload 0x00 then CRC 0xF3 MSB-first
`ifdef CRC8_CHK_STRIP_EN
      pv_cnt = 0; pl_cnt = 0; pd_or = 0; pl_at_last = 0;
`endif
      send(2'b00, 0);
      check("run_busy", busy, 1);
      send_frame(32'h0000_CF00 >> 2, 7, -1);
      check("f1_done", done, 1);
      check("f1_ok", crc_ok, 1);
      check("f1_err", crc_err, 0);
      check("f1_len", len_err, 0);
      check("f1_residue", residue, 8'h00);
      check("f1_beats", frame_beats, 8);
      check("f1_ready_done", in_ready, 0);
      check("f1_max8_ok", crc_ok8, 1);
      check("f1_max8_beats", frame_beats8, 8);
`ifdef CRC8_CHK_STRIP_EN
      check("f1_pay_count", pv_cnt, 4);
      check("f1_pay_data", pd_or, 0);
      check("f1_pay_last_count", pl_cnt, 1);
      check("f1_pay_last_pos", pl_at_last, 1);
`endif
      next_cycle();
      check("f1_done_pulse", done, 0);
      check("f1_ready_after", in_ready, 1);
      check("f1_ok_held", crc_ok, 1);

      // corrupted second beat: din[0] flipped, residue 0xAE
      send_frame(32'h0000_CF04, 8, -1);
      check("bad_done", done, 1);
      check("bad_ok", crc_ok, 0);
      check("bad_err", crc_err, 1);
      check("bad_len", len_err, 0);
      check("bad_residue", residue, 8'hAE);

      // empty payload
`ifdef CRC8_CHK_STRIP_EN
      pv_cnt = 0; pl_cnt = 0;
`endif
      send_frame(32'h0000_00FF, 4, -1);
      check("empty_ok", crc_ok, 1);
      check("empty_err", crc_err, 0);
      check("empty_beats", frame_beats, 4);
      check("empty_residue", residue, 8'h00);
`ifdef CRC8_CHK_STRIP_EN
      check("empty_pay_count", pv_cnt, 0);
      check("empty_pay_last", pl_cnt, 0);
`endif

      // three-beat frame is too short
      send_frame(32'h0000_003F, 3, -1);
      check("short_len", len_err, 1);
      check("short_ok", crc_ok, 0);
      check("short_err", crc_err, 0);
      check("short_beats", frame_beats, 3);
      check("short_residue", residue, 8'hC0);

      // gap of 3 idle cycles, then back-to-back frame
      send_frame(32'h0000_CF00, 8, 3);
      check("gap_done", done, 1);
      check("gap_ok", crc_ok, 1);
      check("gap_residue", residue, 8'h00);
      check("gap_beats", frame_beats, 8);
      check("gap_ready_done", in_ready, 0);
      send_frame(32'h0000_00FF, 4, -1);
      check("b2b_done", done, 1);
      check("b2b_ok", crc_ok, 1);
      check("b2b_beats", frame_beats, 4);

      // init after five beats aborts the frame
      next_cycle();
      for (int i = 0; i < 5; i++) send(2'b00, 0);
      @(negedge clk);
      init = 1;
      @(posedge clk);
      #1 init = 0;
      check("init_busy", busy, 0);
      check("init_done", done, 0);
      check("init_ready", in_ready, 1);
      next_cycle();
      check("init_no_done", done, 0);
      send_frame(32'h0000_CF00, 8, -1);
      check("post_init_done", done, 1);
      check("post_init_ok", crc_ok, 1);
      check("post_init_beats", frame_beats, 8);

      // 9 beats on the MAX_BEATS=8 instance
      send_frame(32'h0002_0000, 9, -1);
      check("over9_len8", len_err8, 1);
      check("over9_beats8", frame_beats8, 9);
      check("over9_ok8", crc_ok8, 0);
      check("over9_err8", crc_err8, 0);
      check("over9_done8", done8, 1);
      check("over9_len", len_err, 0);
      check("over9_beats", frame_beats, 9);

      // 12 beats: counter stays saturated at MAX_BEATS+1
      send_frame(32'h0000_0000, 12, -1);
      check("over12_beats8", frame_beats8, 9);
      check("over12_len8", len_err8, 1);
      check("over12_beats", frame_beats, 12);

      next_cycle();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
